// File: rtl/axis_deserializer_pkg.sv
// Shared defaults for the AXI-Stream narrow-to-wide deserializer.
package axis_deserializer_pkg;

  localparam int DEFAULT_DATA_NB    = 3;
  localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/axis_deserializer.sv
// Packs DATA_NB narrow AXI-Stream beats into one wide word, lane 0 first,
// closing early on up_last and holding the output word under backpressure.
module axis_deserializer
  import axis_deserializer_pkg::*;
#(
  parameter int DATA_NB    = DEFAULT_DATA_NB,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         up_data,
  input  logic                          up_valid,
  output logic                          up_ready,
  input  logic                          up_last,
  output logic [DATA_NB*DATA_WIDTH-1:0] down_data,
  output logic [DATA_NB-1:0]            down_keep,
  output logic                          down_last,
  output logic                          down_valid,
  input  logic                          down_ready
);

  localparam int WORD_WIDTH = DATA_NB * DATA_WIDTH;

  logic [DATA_NB-1:0]    token_q, token_d;
  logic [WORD_WIDTH-1:0] lanes_q, lanes_d;
  logic [WORD_WIDTH-1:0] down_data_q, down_data_d;
  logic [DATA_NB-1:0]    down_keep_q, down_keep_d;
  logic                  down_last_q, down_last_d;
  logic                  down_valid_q, down_valid_d;

  logic [WORD_WIDTH-1:0] lanes_ins;
  logic [DATA_NB-1:0]    lane_mask;
  logic                  mask_acc;
  logic                  accept_beat;
  logic                  complete;

  // Only a completing beat can collide with a held output word.
  assign up_ready    = ~down_valid_q | down_ready | (~token_q[DATA_NB-1] & ~up_last);
  assign accept_beat = up_valid & up_ready;
  assign complete    = accept_beat & (token_q[DATA_NB-1] | up_last);

  assign down_data  = down_data_q;
  assign down_keep  = down_keep_q;
  assign down_last  = down_last_q;
  assign down_valid = down_valid_q;

  // Keep mask: every lane at or below the token position carries data.
  always_comb begin
    lane_mask = '0;
    mask_acc  = 1'b0;
    for (int i = DATA_NB - 1; i >= 0; i--) begin
      mask_acc     = mask_acc | token_q[i];
      lane_mask[i] = mask_acc;
    end
  end

  always_comb begin
    lanes_ins = lanes_q;
    for (int i = 0; i < DATA_NB; i++) begin
      if (token_q[i]) begin
        lanes_ins[i*DATA_WIDTH +: DATA_WIDTH] = up_data;
      end
    end

    token_d      = token_q;
    lanes_d      = lanes_q;
    down_data_d  = down_data_q;
    down_keep_d  = down_keep_q;
    down_last_d  = down_last_q;
    down_valid_d = down_valid_q;

    if (down_valid_q && down_ready) begin
      down_valid_d = 1'b0;
    end

    if (accept_beat) begin
      if (complete) begin
        // Lanes are cleared here so a later short packet reads zeros above its last lane.
        token_d      = '0;
        token_d[0]   = 1'b1;
        lanes_d      = '0;
        down_data_d  = lanes_ins;
        down_keep_d  = lane_mask;
        down_last_d  = up_last;
        down_valid_d = 1'b1;
      end else begin
        token_d = (token_q << 1) | (token_q >> (DATA_NB - 1));
        lanes_d = lanes_ins;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      token_q      <= '0;
      token_q[0]   <= 1'b1;
      lanes_q      <= '0;
      down_data_q  <= '0;
      down_keep_q  <= '0;
      down_last_q  <= 1'b0;
      down_valid_q <= 1'b0;
    end else begin
      token_q      <= token_d;
      lanes_q      <= lanes_d;
      down_data_q  <= down_data_d;
      down_keep_q  <= down_keep_d;
      down_last_q  <= down_last_d;
      down_valid_q <= down_valid_d;
    end
  end

endmodule

// File: tb/tb_axis_deserializer.sv
// Scoreboard bench for axis_deserializer (DATA_NB=3, DATA_WIDTH=8): a lane-index
// model queues expected words on each accepted beat; transfers pop and compare.
module tb_axis_deserializer;

  localparam int NB = 3;
  localparam int W  = 8;

  typedef struct {
    logic [NB*W-1:0] data;
    logic [NB-1:0]   keep;
    logic            last;
  } word_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    up_data;
  logic            up_valid;
  logic            up_ready;
  logic            up_last;
  logic [NB*W-1:0] down_data;
  logic [NB-1:0]   down_keep;
  logic            down_last;
  logic            down_valid;
  logic            down_ready;

  word_t           expQ[$];
  logic [NB*W-1:0] gotData[$];
  logic [NB-1:0]   gotKeep[$];
  logic            gotLast[$];
  int              gotCycle[$];

  logic [NB*W-1:0] mLanes;
  int              mIdx;
  int              checkCount = 0;
  int              failCount  = 0;
  int              cycleNum   = 0;
  int              stallCount = 0;
  bit              toggleReady = 0;
  bit              holdPrev = 0;
  logic [31:0]     holdSnap;

  axis_deserializer #(.DATA_NB(NB), .DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_data    (up_data),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_last    (up_last),
    .down_data  (down_data),
    .down_keep  (down_keep),
    .down_last  (down_last),
    .down_valid (down_valid),
    .down_ready (down_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelAccept(input logic [W-1:0] data, input logic last);
    word_t w;
    mLanes[mIdx*W +: W] = data;
    if (mIdx == NB - 1 || last) begin
      w.data = mLanes;
      w.keep = NB'((1 << (mIdx + 1)) - 1);
      w.last = last;
      expQ.push_back(w);
      mLanes = '0;
      mIdx   = 0;
    end else begin
      mIdx++;
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic stepCycle(output bit accepted);
    word_t w;
    #1;
    accepted = 0;
    if (holdPrev) begin
      checkOutput("hold_stable", {3'b0, down_valid, down_data, down_keep, down_last}, holdSnap);
    end
    holdPrev = down_valid & ~down_ready;
    holdSnap = {3'b0, 1'b1, down_data, down_keep, down_last};
    if (down_valid && down_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("sb_underflow", 32'd1, 32'd0);
      end else begin
        w = expQ.pop_front();
        checkOutput("word_data", 32'(down_data), 32'(w.data));
        checkOutput("word_keep", 32'(down_keep), 32'(w.keep));
        checkOutput("word_last", 32'(down_last), 32'(w.last));
      end
      gotData.push_back(down_data);
      gotKeep.push_back(down_keep);
      gotLast.push_back(down_last);
      gotCycle.push_back(cycleNum);
    end
    if (up_valid && !up_ready) stallCount++;
    if (up_valid && up_ready) begin
      modelAccept(up_data, up_last);
      accepted = 1;
    end
    @(posedge clk);
    cycleNum++;
    @(negedge clk);
    if (toggleReady) down_ready = ~down_ready;
  endtask

  task automatic applyStimulus(input logic [W-1:0] data, input logic last);
    bit acc;
    int waited;
    up_valid = 1'b1;
    up_data  = data;
    up_last  = last;
    acc      = 0;
    waited   = 0;
    while (!acc && waited < 40) begin
      stepCycle(acc);
      waited++;
    end
    if (!acc) checkOutput("up_accept_timeout", 32'd0, 32'd1);
    up_valid = 1'b0;
    up_last  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    bit dummy;
    for (int i = 0; i < n; i++) stepCycle(dummy);
  endtask

  task automatic resetModel();
    expQ.delete();
    mLanes   = '0;
    mIdx     = 0;
    holdPrev = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    rst        = 1'b0;
    up_data    = '0;
    up_valid   = 1'b0;
    up_last    = 1'b0;
    down_ready = 1'b1;
    resetModel();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_valid", 32'(down_valid), 32'd0);
    checkOutput("reset_data", 32'(down_data), 32'd0);
    checkOutput("reset_keep", 32'(down_keep), 32'd0);
    checkOutput("reset_last", 32'(down_last), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("ready_after_reset", 32'(up_ready), 32'd1);
    @(negedge clk);

    // Continuous flow
    $display("[TB] continuous flow");
    base = gotData.size();
    stallCount = 0;
    for (int i = 1; i <= 6; i++) applyStimulus(8'(i), 1'b0);
    idleCycles(2);
    checkOutput("flow_no_stall", 32'(stallCount), 32'd0);
    checkOutput("flow_words", 32'(gotData.size() - base), 32'd2);
    if (gotData.size() >= base + 2) begin
      checkOutput("flow_word0", 32'(gotData[base]), 32'h030201);
      checkOutput("flow_word1", 32'(gotData[base+1]), 32'h060504);
      checkOutput("flow_keep0", 32'(gotKeep[base]), 32'h7);
      checkOutput("flow_last1", 32'(gotLast[base+1]), 32'd0);
      checkOutput("flow_spacing", 32'(gotCycle[base+1] - gotCycle[base]), 32'd3);
    end

    // Backpressure
    $display("[TB] backpressure");
    base = gotData.size();
    down_ready = 1'b0;
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b0);
    up_valid = 1'b1;
    up_data  = 8'd6;
    up_last  = 1'b0;
    #1;
    checkOutput("bp_ready_low", 32'(up_ready), 32'd0);
    checkOutput("bp_valid", 32'(down_valid), 32'd1);
    checkOutput("bp_held_data", 32'(down_data), 32'h030201);
    idleCycles(2);
    down_ready = 1'b1;
    applyStimulus(8'd6, 1'b0);
    idleCycles(2);
    checkOutput("bp_words", 32'(gotData.size() - base), 32'd2);
    if (gotData.size() >= base + 2) begin
      checkOutput("bp_word0", 32'(gotData[base]), 32'h030201);
      checkOutput("bp_word1", 32'(gotData[base+1]), 32'h060504);
      checkOutput("bp_gap", 32'(gotCycle[base+1] - gotCycle[base]), 32'd1);
    end

    // Partial packet then single-beat packet
    $display("[TB] partial packets");
    base = gotData.size();
    applyStimulus(8'hA1, 1'b0);
    applyStimulus(8'hA2, 1'b1);
    applyStimulus(8'h7F, 1'b1);
    idleCycles(2);
    checkOutput("partial_words", 32'(gotData.size() - base), 32'd2);
    if (gotData.size() >= base + 2) begin
      checkOutput("partial_data", 32'(gotData[base]), 32'h00A2A1);
      checkOutput("partial_keep", 32'(gotKeep[base]), 32'h3);
      checkOutput("partial_last", 32'(gotLast[base]), 32'd1);
      checkOutput("single_data", 32'(gotData[base+1]), 32'h00007F);
      checkOutput("single_keep", 32'(gotKeep[base+1]), 32'h1);
      checkOutput("single_last", 32'(gotLast[base+1]), 32'd1);
    end

    // Reset mid-word with a held output word
    $display("[TB] reset mid-word");
    down_ready = 1'b0;
    for (int i = 1; i <= 3; i++) applyStimulus(8'(i), 1'b0);
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h22, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("midreset_valid", 32'(down_valid), 32'd0);
    checkOutput("midreset_data", 32'(down_data), 32'd0);
    resetModel();
    down_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midreset_ready", 32'(up_ready), 32'd1);
    @(negedge clk);
    base = gotData.size();
    applyStimulus(8'd9, 1'b0);
    applyStimulus(8'd8, 1'b0);
    applyStimulus(8'd7, 1'b0);
    idleCycles(2);
    checkOutput("midreset_words", 32'(gotData.size() - base), 32'd1);
    if (gotData.size() >= base + 1) begin
      checkOutput("midreset_word", 32'(gotData[base]), 32'h070809);
    end

    // Toggled down_ready over 60 beats
    $display("[TB] toggled ready");
    toggleReady = 1;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(8'($urandom_range(0, 255)), (i == 59) || ($urandom_range(0, 7) == 0));
    end
    toggleReady = 0;
    down_ready  = 1'b1;
    idleCycles(4);
    checkOutput("sb_empty", 32'(expQ.size()), 32'd0);
    checkOutput("model_idle", 32'(mIdx), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/axis_deserializer.md
AXIS_DESERIALIZER -- requirements
Module: axis_deserializer

Interface
REQ-001 Parameter DATA_NB, default 3: number of narrow beats packed into one wide word; legal range 1 to 16.
REQ-002 Parameter DATA_WIDTH, default 8: width of one narrow beat in bits.
REQ-003 Port clk  input  1: single clock; all logic is on the rising edge.
REQ-004 Port rst  input  1: asynchronous, active-low reset.
REQ-005 Port up_data  input  DATA_WIDTH: narrow upstream beat.
REQ-006 Port up_valid  input  1: upstream beat valid.
REQ-007 Port up_ready  output  1: block accepts the upstream beat this cycle.
REQ-008 Port up_last  input  1: the beat is the final beat of a packet.
REQ-009 Port down_data  output  DATA_NB*DATA_WIDTH: assembled wide word.
REQ-010 Port down_keep  output  DATA_NB: per-lane valid mask; bit i qualifies lane i.
REQ-011 Port down_last  output  1: the word closes a packet.
REQ-012 Port down_valid  output  1: wide word valid.
REQ-013 Port down_ready  input  1: downstream accepts the wide word.

Function
REQ-014 An upstream beat is accepted only on a clock edge where up_valid & up_ready; a downstream word transfers only on an edge where down_valid & down_ready.
REQ-015 Packing order: the first accepted beat of a word goes to lane 0 (bits DATA_WIDTH-1:0); beat k goes to lane k.
REQ-016 A one-hot token[DATA_NB-1:0] tracks the next lane to fill: token = 1 after reset, rotates left on each accepted beat, and returns to 1 after a word completes.
REQ-017 A word completes when the accepted beat lands in lane DATA_NB-1, or when up_last=1 is accepted in any lane.
REQ-018 On completion, on that same edge, the assembly lanes plus the completing beat load into the output register, down_valid goes to 1, down_keep is set to ones for lanes 0..k (k = completing lane), and down_last takes the value of up_last.
REQ-019 Latency: down_valid is asserted the cycle after the completing beat is accepted.
REQ-020 Lanes above k on a partial (up_last) word are driven to zero.
REQ-021 up_ready = ~down_valid | down_ready | ~token[DATA_NB-1] & ~up_last. The block never stalls upstream except when a completing beat would overwrite an unaccepted output word.
REQ-022 Throughput: with up_valid and down_ready held high, one beat is accepted every cycle and one word is produced every DATA_NB cycles, with no bubbles.
REQ-023 Simultaneous events: if a completing beat is accepted on the same edge that the current word transfers downstream, the new word loads and down_valid stays 1.
REQ-024 If a word transfers and no completing beat is accepted on that edge, down_valid goes to 0.
REQ-025 While down_valid=1 and down_ready=0, down_data, down_keep and down_last hold stable.
REQ-026 Non-completing beats are always accepted, so up to DATA_NB-1 lanes can fill while the output is held.
REQ-027 With DATA_NB=1, every accepted beat completes a word; down_keep = 1; the block behaves as a one-deep register slice.

Reset
REQ-028 When rst=0, the following take effect asynchronously: down_valid = 0, down_last = 0, down_keep = 0, down_data = 0, token = 1, and all assembly lanes = 0.
REQ-029 A reset asserted mid-word discards the partial word and any unaccepted output word; after release, the next accepted beat goes to lane 0.
REQ-030 up_ready = 1 in the first cycle after reset deasserts.

Structure
REQ-031 No shared package is required; DATA_NB and DATA_WIDTH are module parameters, and the lane mask is derived locally.
REQ-032 Single module. The token/assembly datapath and the output register stay in one file; no sub-module is instantiated.

Verification
REQ-033 Continuous flow: DATA_NB=3, DATA_WIDTH=8, beats 1,2,3,4,5,6, up_last=0, down_ready=1 -> words 0x030201 then 0x060504, each with down_keep=3'b111 and down_last=0, no upstream stall.
REQ-034 Backpressure: down_ready=0 while 6 beats are offered -> first word held stable; beats 4 and 5 are accepted, then up_ready=0 with beat 6 pending; raising down_ready -> 0x030201 transfers, 0x060504 follows one cycle later.
REQ-035 Partial packet: beats 0xA1, 0xA2 with up_last on 0xA2 -> down_data=0x00A2A1, down_keep=3'b011, down_last=1; the next beat lands in lane 0.
REQ-036 Single-beat last: 0x7F with up_last=1 -> down_data=0x00007F, down_keep=3'b001, down_last=1.
REQ-037 Reset mid-word: accept 2 beats, pulse rst low -> down_valid=0 immediately; after release, beats 9,8,7 -> 0x070809.
REQ-038 Toggled down_ready (alternating each cycle) over 60 beats -> every word matches the sent order with none lost or duplicated; a scoreboard compares the output against the serializer-order model.
